// File: rtl/data_ram_ctrl.sv
// Data-side memory responder for the load/store bus: captures one request,
// waits WAIT_CYCLES cycles, then acks for one cycle with registered read data.
module data_ram_ctrl #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ack_o,
  output logic        err_o,
  output logic        stallreq_o
);

  localparam int          DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [3:0]  CNT_INIT  = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t                state;
  state_t                next_state;
  logic [3:0]            cnt;
  logic [3:0]            cnt_next;
  logic                  capture;
  logic                  complete;

  logic                  req_we;
  logic [31:0]           req_addr;
  logic [3:0]            req_sel;
  logic [31:0]           req_data;

  logic                  cur_we;
  logic [31:0]           cur_addr;
  logic [3:0]            cur_sel;
  logic [31:0]           cur_data;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  in_range;
  logic                  do_write;

  logic [31:0]           mem [DEPTH];

  // With zero wait states the request completes on its capture edge, so the
  // live bus is the request while IDLE; afterwards only the captured copy counts.
  always_comb begin
    cur_we   = req_we;
    cur_addr = req_addr;
    cur_sel  = req_sel;
    cur_data = req_data;
    if (state == IDLE) begin
      cur_we   = we_i;
      cur_addr = addr_i;
      cur_sel  = sel_i;
      cur_data = data_i;
    end
  end

  assign word_idx   = cur_addr[ADDR_WIDTH+1:2];
  assign in_range   = (cur_addr >> (ADDR_WIDTH + 2)) == 32'd0;
  assign do_write   = complete && in_range && cur_we && !rst;
  assign stallreq_o = ce_i & ~ack_o & ~rst;

  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    capture    = 1'b0;
    complete   = 1'b0;
    case (state)
      IDLE: begin
        if (ce_i) begin
          capture = 1'b1;
          if (WAIT_CYCLES == 0) begin
            next_state = RESP;
            complete   = 1'b1;
          end else begin
            next_state = WAIT;
            cnt_next   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (!ce_i) begin
          next_state = IDLE;
        end else if (cnt == 4'd0) begin
          next_state = RESP;
          complete   = 1'b1;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      RESP: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      ack_o    <= 1'b0;
      err_o    <= 1'b0;
      data_o   <= ZERO_WORD;
      req_we   <= 1'b0;
      req_addr <= 32'd0;
      req_sel  <= 4'd0;
      req_data <= 32'd0;
    end else begin
      state  <= next_state;
      cnt    <= cnt_next;
      ack_o  <= complete;
      err_o  <= complete & ~in_range;
      data_o <= (complete && in_range && !cur_we) ? mem[word_idx] : ZERO_WORD;
      if (capture) begin
        req_we   <= we_i;
        req_addr <= addr_i;
        req_sel  <= sel_i;
        req_data <= data_i;
      end
    end
  end

  // The array is deliberately outside the reset so its contents survive rst.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (cur_sel[b]) begin
          mem[word_idx][8*b +: 8] <= cur_data[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_ram_ctrl.sv
// Randomized bench for data_ram_ctrl: three instances (1, 3 and 0 wait states)
// checked every cycle against a request-level model of memory and ack timing.
module tb_data_ram_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        ce    [3];
  logic        we    [3];
  logic [31:0] addr  [3];
  logic [3:0]  sel   [3];
  logic [31:0] wdata [3];
  logic [31:0] rdata [3];
  logic        ack   [3];
  logic        err   [3];
  logic        stall [3];

  int tests    = 0;
  int failures = 0;
  int cycle    = 0;
  bit checking = 1'b0;

  int          exp_ack_cycle [3] = '{-1, -1, -1};
  logic [31:0] exp_data [3]      = '{32'h0, 32'h0, 32'h0};
  logic        exp_err  [3]      = '{1'b0, 1'b0, 1'b0};
  logic [31:0] model_mem [int];

  logic [31:0] last_data;
  logic        last_ack;
  logic        last_err;

  data_ram_ctrl #(.ADDR_WIDTH(10), .WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .rst(rst), .ce_i(ce[0]), .we_i(we[0]), .addr_i(addr[0]),
    .sel_i(sel[0]), .data_i(wdata[0]), .data_o(rdata[0]), .ack_o(ack[0]),
    .err_o(err[0]), .stallreq_o(stall[0])
  );

  data_ram_ctrl #(.ADDR_WIDTH(10), .WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .rst(rst), .ce_i(ce[1]), .we_i(we[1]), .addr_i(addr[1]),
    .sel_i(sel[1]), .data_i(wdata[1]), .data_o(rdata[1]), .ack_o(ack[1]),
    .err_o(err[1]), .stallreq_o(stall[1])
  );

  data_ram_ctrl #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst(rst), .ce_i(ce[2]), .we_i(we[2]), .addr_i(addr[2]),
    .sel_i(sel[2]), .data_i(wdata[2]), .data_o(rdata[2]), .ack_o(ack[2]),
    .err_o(err[2]), .stallreq_o(stall[2])
  );

  function automatic int wait_of(int i);
    case (i)
      0:       return 1;
      1:       return 3;
      default: return 0;
    endcase
  endfunction

  function automatic bit addr_ok(logic [31:0] a);
    return (a >> 12) == 32'd0;
  endfunction

  function automatic int key_of(int i, logic [31:0] a);
    return i * 4096 + int'(a[11:2]);
  endfunction

  task automatic check_output(string name, int i, logic [31:0] actual, logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s inst%0d cycle %0d: got %h, expected %h", name, i, cycle, actual, expected);
    end
  endtask

  always @(posedge clk) cycle <= cycle + 1;

  // Every cycle, each instance's outputs must match the model's ack schedule.
  always @(negedge clk) begin
    bit ea;
    if (checking) begin
      for (int i = 0; i < 3; i++) begin
        ea = (cycle == exp_ack_cycle[i]);
        check_output("ack",   i, 32'(ack[i]),   32'(ea));
        check_output("err",   i, 32'(err[i]),   32'(ea & exp_err[i]));
        check_output("data",  i, rdata[i],      ea ? exp_data[i] : 32'h0);
        check_output("stall", i, 32'(stall[i]), 32'(ce[i] & ~ea & ~rst));
      end
    end
  end

  task automatic begin_cycle();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int j = 0; j < 3; j++) ce[j] = 1'b0;
  endtask

  task automatic go_idle(int n);
    repeat (n) begin_cycle();
  endtask

  // One request held per the stall protocol; returns during its ack cycle.
  task automatic apply_stimulus(int i, logic w, logic [31:0] a, logic [3:0] s, logic [31:0] d);
    int          key;
    logic [31:0] word;
    begin_cycle();
    ce[i]    = 1'b1;
    we[i]    = w;
    addr[i]  = a;
    sel[i]   = s;
    wdata[i] = d;
    exp_err[i]  = !addr_ok(a);
    exp_data[i] = 32'h0;
    if (addr_ok(a)) begin
      key = key_of(i, a);
      if (w) begin
        word = model_mem.exists(key) ? model_mem[key] : 32'h0;
        for (int b = 0; b < 4; b++) begin
          if (s[b]) word[8*b +: 8] = d[8*b +: 8];
        end
        model_mem[key] = word;
      end else begin
        exp_data[i] = model_mem[key];
      end
    end
    exp_ack_cycle[i] = cycle + 1 + wait_of(i);
    for (int k = 0; k <= wait_of(i); k++) begin
      @(posedge clk);
      #1;
      we[i]    = 1'($urandom);
      addr[i]  = $urandom;
      sel[i]   = 4'($urandom);
      wdata[i] = $urandom;
    end
    last_ack  = ack[i];
    last_err  = err[i];
    last_data = rdata[i];
  endtask

  // Store aborted in its second wait cycle by dropping ce or pulsing rst.
  task automatic flush_access(int i, bit use_reset, logic [31:0] a, logic [31:0] d);
    begin_cycle();
    ce[i]    = 1'b1;
    we[i]    = 1'b1;
    addr[i]  = a;
    sel[i]   = 4'hF;
    wdata[i] = d;
    exp_ack_cycle[i] = -1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    if (use_reset) rst = 1'b1;
    else           ce[i] = 1'b0;
  endtask

  initial begin
    int          i;
    int          r;
    logic [31:0] a;

    rst = 1'b1;
    for (int j = 0; j < 3; j++) begin
      ce[j] = 1'b1; we[j] = 1'b0; addr[j] = 32'h0; sel[j] = 4'h0; wdata[j] = 32'h0;
    end
    @(posedge clk);
    checking = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int j = 0; j < 3; j++) ce[j] = 1'b0;
    go_idle(2);

    for (int k = 0; k < 3; k++) begin
      for (int idx = 0; idx < 16; idx++) begin
        apply_stimulus(k, 1'b1, 32'(idx) << 2, 4'hF, 32'hA5A5_0000 | (32'(k) << 8) | 32'(idx));
      end
    end

    apply_stimulus(0, 1'b1, 32'h100, 4'hF, 32'hDEAD_BEEF);
    check_output("lit_store_ack", 0, 32'(last_ack), 32'd1);
    apply_stimulus(0, 1'b0, 32'h100, 4'hF, 32'h0);
    check_output("lit_load_full", 0, last_data, 32'hDEAD_BEEF);
    apply_stimulus(0, 1'b1, 32'h100, 4'b0010, 32'h0000_1100);
    apply_stimulus(0, 1'b0, 32'h100, 4'hF, 32'h0);
    check_output("lit_byte_lane", 0, last_data, 32'hDEAD_11EF);
    check_output("model_pin", 0, model_mem[key_of(0, 32'h100)], 32'hDEAD_11EF);
    apply_stimulus(0, 1'b1, 32'h102, 4'b0000, 32'hFFFF_FFFF);
    check_output("lit_sel0_ack", 0, 32'(last_ack), 32'd1);
    apply_stimulus(0, 1'b0, 32'h101, 4'hF, 32'h0);
    check_output("lit_sel0_keep", 0, last_data, 32'hDEAD_11EF);
    apply_stimulus(0, 1'b1, 32'h1000, 4'hF, 32'h5555_5555);
    check_output("lit_oor_store_err", 0, 32'(last_err), 32'd1);
    apply_stimulus(0, 1'b0, 32'h1000, 4'hF, 32'h0);
    check_output("lit_oor_load_err", 0, 32'(last_err), 32'd1);
    check_output("lit_oor_load_data", 0, last_data, 32'h0);
    apply_stimulus(0, 1'b0, 32'h0, 4'hF, 32'h0);
    check_output("lit_word0_keep", 0, last_data, 32'hA5A5_0000);
    go_idle(2);

    apply_stimulus(1, 1'b1, 32'h100, 4'hF, 32'hCAFE_F00D);
    flush_access(1, 1'b0, 32'h100, 32'h1234_5678);
    apply_stimulus(1, 1'b0, 32'h100, 4'hF, 32'h0);
    check_output("lit_flush_keep", 1, last_data, 32'hCAFE_F00D);
    flush_access(1, 1'b1, 32'h100, 32'h1234_5678);
    apply_stimulus(1, 1'b0, 32'h100, 4'hF, 32'h0);
    check_output("lit_reset_keep", 1, last_data, 32'hCAFE_F00D);
    go_idle(2);

    apply_stimulus(2, 1'b0, 32'h4, 4'hF, 32'h0);
    check_output("lit_b2b_first", 2, last_data, 32'hA5A5_0201);
    apply_stimulus(2, 1'b0, 32'h8, 4'hF, 32'h0);
    check_output("lit_b2b_second", 2, last_data, 32'hA5A5_0202);
    go_idle(2);

    repeat (150) begin
      i = $urandom_range(0, 2);
      r = $urandom_range(0, 9);
      if (r == 0) begin
        go_idle($urandom_range(1, 3));
      end else if (r == 1 && i == 1) begin
        flush_access(1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)) << 2, $urandom);
      end else begin
        if (r == 2) a = 32'h1000 | $urandom;
        else        a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
        apply_stimulus(i, 1'($urandom), a, 4'($urandom), $urandom);
      end
    end
    go_idle(3);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
